// File: rtl/cpu_pkg.sv
// Shared register-file writeback types: widths, the hard-wired zero register,
// and the {rd, data} record carried through the writeback queue.
package cpu_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue: up to two pushes and one pop per cycle, with the contents
// exported oldest-first so the owner can scan them for forwarding.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  wb_entry_t                push0_entry,
  input  logic                     push1,
  input  wb_entry_t                push1_entry,
  input  logic                     pop,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                head,
  output wb_entry_t                age_entry [DEPTH],
  output logic [DEPTH-1:0]         age_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    wr_ptr_nx;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_nx = wr_ptr_q + PW'(1);
    // push0 is the older write; if only push1 is present it still lands at wr_ptr
    if (push0) begin
      mem_d[wr_ptr_q] = push0_entry;
      if (push1) mem_d[wr_ptr_nx] = push1_entry;
    end else if (push1) begin
      mem_d[wr_ptr_q] = push1_entry;
    end
    wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
    mem_q <= mem_d;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entry[i] = mem_q[rd_ptr_q + PW'(i)];
      age_valid[i] = CW'(i) < count_q;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges ALU and load writebacks into the register file's single write port
// through an in-order queue, and answers two forwarding queries against it.
module rf_wb_arbiter
  import cpu_pkg::wb_entry_t;
  import cpu_pkg::REG_ZERO;
#(
  parameter int DEPTH = 4,
  parameter int DW    = cpu_pkg::DW,
  parameter int AW    = cpu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic          RFWr,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD,
  input  logic [AW-1:0] q1_addr,
  output logic          q1_hit,
  output logic [DW-1:0] q1_data,
  input  logic [AW-1:0] q2_addr,
  output logic          q2_hit,
  output logic [DW-1:0] q2_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = CW + 1;

  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  wb_entry_t        head;
  wb_entry_t        age_entry [DEPTH];
  logic [DEPTH-1:0] age_valid;
  wb_entry_t        mem_entry, alu_entry;
  logic [FW-1:0]    free;
  logic             mem_push, alu_push;

  assign mem_entry = '{rd: mem_rd, data: mem_data};
  assign alu_entry = '{rd: alu_rd, data: alu_data};

  // Valid/ready: a source transfers on any edge where valid && ready; ready never
  // looks at the source's own valid, and the load keeps priority as the older op.
  always_comb begin
    free      = FW'(DEPTH) - FW'(fifo_count) + FW'(RFWr);
    mem_ready = (free >= FW'(1));
    alu_ready = mem_valid ? (free >= FW'(2)) : (free >= FW'(1));
    mem_push  = mem_valid && mem_ready && (mem_rd != REG_ZERO);
    alu_push  = alu_valid && alu_ready && (alu_rd != REG_ZERO);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0       (mem_push),
    .push0_entry (mem_entry),
    .push1       (alu_push),
    .push1_entry (alu_entry),
    .pop         (RFWr),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .head        (head),
    .age_entry   (age_entry),
    .age_valid   (age_valid)
  );

  assign RFWr = !fifo_empty;
  assign A3   = RFWr ? head.rd   : '0;
  assign WD   = RFWr ? head.data : '0;

  // Oldest-first scan: later matches overwrite earlier ones, leaving the youngest.
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && (q1_addr != REG_ZERO) && (age_entry[i].rd == q1_addr)) begin
        q1_hit  = 1'b1;
        q1_data = age_entry[i].data;
      end
      if (age_valid[i] && (q2_addr != REG_ZERO) && (age_entry[i].rd == q2_addr)) begin
        q2_hit  = 1'b1;
        q2_data = age_entry[i].data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: a reference queue model predicts readies, the RF
// write stream and forwarding answers every cycle.
module tb_rf_wb_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int EW    = AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_rd = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ready;
  logic          RFWr;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic [AW-1:0] q1_addr = '0;
  logic          q1_hit;
  logic [DW-1:0] q1_data;
  logic [AW-1:0] q2_addr = '0;
  logic          q2_hit;
  logic [DW-1:0] q2_data;

  rf_wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .RFWr      (RFWr),
    .A3        (A3),
    .WD        (WD),
    .q1_addr   (q1_addr),
    .q1_hit    (q1_hit),
    .q1_data   (q1_data),
    .q2_addr   (q2_addr),
    .q2_hit    (q2_hit),
    .q2_data   (q2_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic m_acc, a_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_query(input logic [AW-1:0] a, output logic hit,
                                      output logic [DW-1:0] d);
    logic [EW-1:0] e;
    hit = 1'b0;
    d   = '0;
    if (a != REG_ZERO) begin
      foreach (exp_q[i]) begin
        e = exp_q[i];
        if (e[EW-1:DW] == a) begin
          hit = 1'b1;
          d   = e[DW-1:0];
        end
      end
    end
  endfunction

  // One clock cycle: compare all outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    int            n;
    int            free;
    logic          exp_mr, exp_ar, h;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    @(negedge clk);
    n = exp_q.size();
    e = (n > 0) ? exp_q[0] : '0;
    check_eq("rfwr", 64'(RFWr), 64'(n > 0));
    check_eq("a3", 64'(A3), 64'(e[EW-1:DW]));
    check_eq("wd", 64'(WD), 64'(e[DW-1:0]));
    free   = DEPTH - n + ((n > 0) ? 1 : 0);
    exp_mr = (free >= 1);
    exp_ar = mem_valid ? (free >= 2) : (free >= 1);
    check_eq("mem_ready", 64'(mem_ready), 64'(exp_mr));
    check_eq("alu_ready", 64'(alu_ready), 64'(exp_ar));
    model_query(q1_addr, h, d);
    check_eq("q1_hit", 64'(q1_hit), 64'(h));
    check_eq("q1_data", 64'(q1_data), 64'(d));
    model_query(q2_addr, h, d);
    check_eq("q2_hit", 64'(q2_hit), 64'(h));
    check_eq("q2_data", 64'(q2_data), 64'(d));
    m_acc = rst && mem_valid && exp_mr;
    a_acc = rst && alu_valid && exp_ar;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (n > 0) void'(exp_q.pop_front());
      if (m_acc && mem_rd != REG_ZERO) exp_q.push_back({mem_rd, mem_data});
      if (a_acc && alu_rd != REG_ZERO) exp_q.push_back({alu_rd, alu_data});
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_drop();
    step();
    if (m_acc) mem_valid = 1'b0;
    if (a_acc) alu_valid = 1'b0;
  endtask

  task automatic send_until_done();
    for (int i = 0; i < 20 && (mem_valid || alu_valid); i++) step_drop();
    check_eq("accept_timeout", 64'({mem_valid, alu_valid}), 64'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && exp_q.size() > 0; i++) step();
    step();
  endtask

  task automatic set_mem(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    mem_valid = 1'b1; mem_rd = rd; mem_data = data;
  endtask

  task automatic set_alu(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    alu_valid = 1'b1; alu_rd = rd; alu_data = data;
  endtask

  // Sources only change fields once the previous request has been taken.
  task automatic stream(input int cycles, input int pct, input int rd_lo, input int rd_hi,
                        input bit rand_q);
    for (int c = 0; c < cycles; c++) begin
      if (!mem_valid && $urandom_range(99, 0) < pct)
        set_mem(AW'($urandom_range(rd_hi, rd_lo)), $urandom);
      if (!alu_valid && $urandom_range(99, 0) < pct)
        set_alu(AW'($urandom_range(rd_hi, rd_lo)), $urandom);
      if (rand_q) begin
        q1_addr = AW'($urandom_range(rd_hi, 0));
        q2_addr = AW'($urandom_range(rd_hi, 0));
      end
      step_drop();
    end
    send_until_done();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b1;
    step();

    // reset mid-operation discards three queued writes
    set_mem(5'd11, 32'h1100_0011); set_alu(5'd12, 32'h1200_0012);
    step_drop();
    set_mem(5'd13, 32'h1300_0013); set_alu(5'd14, 32'h1400_0014);
    step_drop();
    q1_addr = 5'd12; q2_addr = 5'd14;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    q1_addr = 5'd13;
    step();
    q1_addr = 5'd14; q2_addr = 5'd12;
    step();

    // simultaneous sources, same rd: load first, ALU wins forwarding
    q1_addr = 5'd5; q2_addr = 5'd0;
    set_mem(5'd5, 32'hAAAA_0001); set_alu(5'd5, 32'hBBBB_0002);
    send_until_done();
    drain();

    // x0 write is accepted but never queued
    q1_addr = 5'd0;
    set_alu(5'd0, 32'h1234_5678);
    send_until_done();
    drain();

    // back-to-back single writes wrap the pointers
    for (int r = 1; r <= 10; r++) begin
      q1_addr = AW'(r);
      set_alu(AW'(r), 32'h1000_0000 + r);
      send_until_done();
    end
    drain();

    // fill with both sources every cycle while draining: hits free==1 backpressure
    q1_addr = '0; q2_addr = '0;
    stream(8, 100, 1, 31, 1'b0);
    drain();

    // forwarding of the head entry in the cycle it is written
    q2_addr = 5'd7;
    set_alu(5'd7, 32'hCAFE_0007);
    send_until_done();
    step();
    step();

    // random traffic with heavy rd aliasing, including x0
    stream(300, 60, 0, 7, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
